alu_result_checker: RTL and testbench

ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_result_checker_if.sv | 11 +
 rtl/alu_ref_model.sv | 17 +
 rtl/alu_result_checker.sv | 154 +++++++++++++++
 tb/tb_alu_result_checker.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: out_sel bit positions, checker state encoding and
// the golden 8-bit result function reused by the checker and ALU benches.
package alu_pkg;

  localparam int SEL_W    = 7;
  localparam int SEL_ADD  = 0;
  localparam int SEL_SUB  = 1;
  localparam int SEL_AND  = 2;
  localparam int SEL_OR   = 3;
  localparam int SEL_XOR  = 4;
  localparam int SEL_NOT  = 5;
  localparam int SEL_PASS = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } chk_state_t;

  function automatic logic sel_is_one_hot(input logic [SEL_W-1:0] sel);
    return (sel != '0) && ((sel & (sel - SEL_W'(1))) == '0);
  endfunction

  // Arithmetic stays 8 bits wide so carry and borrow fall off naturally.
  function automatic logic [7:0] alu_expected(input logic [7:0]       a,
                                              input logic [7:0]       b,
                                              input logic [SEL_W-1:0] sel);
    logic [7:0] r;
    r = '0;
    if (sel[SEL_ADD])       r = a + b;
    else if (sel[SEL_SUB])  r = a - b;
    else if (sel[SEL_AND])  r = a & b;
    else if (sel[SEL_OR])   r = a | b;
    else if (sel[SEL_XOR])  r = a ^ b;
    else if (sel[SEL_NOT])  r = ~a;
    else if (sel[SEL_PASS]) r = a;
    return r;
  endfunction

endpackage

// File: rtl/alu_result_checker_if.sv
// Operand/result bus between the ALU stimulus source and the result checker.
interface alu_result_checker_if;
  logic       sample_valid;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [6:0] out_sel;
  logic [7:0] dut_out;

  modport master (output sample_valid, num1, num2, out_sel, dut_out);
  modport slave  (input  sample_valid, num1, num2, out_sel, dut_out);
endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden model: expected ALU result and out_sel legality.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [7:0]       num1,
  input  logic [7:0]       num2,
  input  logic [SEL_W-1:0] out_sel,
  output logic [7:0]       expected,
  output logic             legal
);

  always_comb begin
    expected = alu_expected(num1, num2, out_sel);
    legal    = sel_is_one_hot(out_sel);
  end

endmodule

// File: rtl/alu_result_checker.sv
// Scoreboard for an ALU: predicts each accepted operation, delays the
// prediction by LATENCY cycles and compares it against the ALU result.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int LATENCY      = 1,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b1
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 on,
  input  logic                 clear,
  alu_result_checker_if.slave  bus,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 mismatch,
  output logic                 illegal_op,
  output logic [7:0]           err_exp,
  output logic [7:0]           err_got,
  output logic [SEL_W-1:0]     err_sel,
  output logic [1:0]           state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chk_state_t cur_state;
  chk_state_t nxt_state;

  logic             active;
  logic [7:0]       exp_val;
  logic             sel_legal;
  logic             accept;
  logic             push;
  logic             check;
  logic             match;
  logic             pipe_empty;
  logic             err_held;

  logic             pipe_valid [LATENCY];
  logic [7:0]       pipe_exp   [LATENCY];
  logic [SEL_W-1:0] pipe_sel   [LATENCY];

  alu_ref_model u_ref_model (
    .num1     (bus.num1),
    .num2     (bus.num2),
    .out_sel  (bus.out_sel),
    .expected (exp_val),
    .legal    (sel_legal)
  );

  // Clear always wins over a same-cycle sample or compare.
  assign accept = on & bus.sample_valid & active & ~clear;
  assign push   = accept & sel_legal;
  assign check  = pipe_valid[LATENCY-1] & active & ~clear;
  assign match  = (pipe_exp[LATENCY-1] == bus.dut_out);

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < LATENCY; i++) begin
      if (pipe_valid[i]) pipe_empty = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_state <= ST_IDLE;
    else      cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    if (clear) begin
      nxt_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE: if (push) nxt_state = ST_RUN;
        ST_RUN: begin
          if (check && !match && STOP_ON_FAIL) nxt_state = ST_FAIL;
          else if (!on && pipe_empty)          nxt_state = ST_IDLE;
        end
        ST_FAIL: nxt_state = ST_FAIL;
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    active = (cur_state != ST_FAIL);
    state  = cur_state;
  end

  // Entries still in flight are thrown away once checking has frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_exp[i]   <= '0;
        pipe_sel[i]   <= '0;
      end
    end else if (clear || !active) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_exp[i]   <= '0;
        pipe_sel[i]   <= '0;
      end
    end else begin
      pipe_valid[0] <= push;
      pipe_exp[0]   <= exp_val;
      pipe_sel[0]   <= bus.out_sel;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_exp[i]   <= pipe_exp[i-1];
        pipe_sel[i]   <= pipe_sel[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      mismatch   <= 1'b0;
      illegal_op <= 1'b0;
      err_exp    <= '0;
      err_got    <= '0;
      err_sel    <= '0;
      err_held   <= 1'b0;
    end else if (clear) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      mismatch   <= 1'b0;
      illegal_op <= 1'b0;
      err_exp    <= '0;
      err_got    <= '0;
      err_sel    <= '0;
      err_held   <= 1'b0;
    end else begin
      mismatch   <= check & ~match;
      illegal_op <= accept & ~sel_legal;
      if (check && match && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_ONE;
      if (check && !match) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_ONE;
        if (!err_held) begin
          err_exp  <= pipe_exp[LATENCY-1];
          err_got  <= bus.dut_out;
          err_sel  <= pipe_sel[LATENCY-1];
          err_held <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: default, LATENCY=3 and CNT_W=4 builds
// share one stimulus bus; each scenario task checks its own expectations.
module tb_alu_result_checker;

  logic clk = 1'b0;
  logic rst;
  logic on;
  logic clear;

  alu_result_checker_if bus ();

  logic [15:0] pass_a, fail_a;
  logic        mis_a, ill_a;
  logic [7:0]  eexp_a, egot_a;
  logic [6:0]  esel_a;
  logic [1:0]  st_a;

  logic [15:0] pass_b, fail_b;
  logic        mis_b, ill_b;
  logic [7:0]  eexp_b, egot_b;
  logic [6:0]  esel_b;
  logic [1:0]  st_b;

  logic [3:0]  pass_c, fail_c;
  logic        mis_c, ill_c;
  logic [7:0]  eexp_c, egot_c;
  logic [6:0]  esel_c;
  logic [1:0]  st_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_checker dut_a (
    .clk(clk), .rst(rst), .on(on), .clear(clear), .bus(bus.slave),
    .pass_cnt(pass_a), .fail_cnt(fail_a), .mismatch(mis_a), .illegal_op(ill_a),
    .err_exp(eexp_a), .err_got(egot_a), .err_sel(esel_a), .state(st_a)
  );

  alu_result_checker #(.LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .on(on), .clear(clear), .bus(bus.slave),
    .pass_cnt(pass_b), .fail_cnt(fail_b), .mismatch(mis_b), .illegal_op(ill_b),
    .err_exp(eexp_b), .err_got(egot_b), .err_sel(esel_b), .state(st_b)
  );

  alu_result_checker #(.CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .on(on), .clear(clear), .bus(bus.slave),
    .pass_cnt(pass_c), .fail_cnt(fail_c), .mismatch(mis_c), .illegal_op(ill_c),
    .err_exp(eexp_c), .err_got(egot_c), .err_sel(esel_c), .state(st_c)
  );

  task automatic apply_reset();
    rst = 1'b0; on = 1'b0; clear = 1'b0;
    bus.sample_valid = 1'b0; bus.num1 = '0; bus.num2 = '0; bus.out_sel = '0; bus.dut_out = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One LATENCY=1 transaction: operands this cycle, ALU result the next.
  task automatic do_op(input logic [7:0] n1, input logic [7:0] n2,
                       input logic [6:0] sel, input logic [7:0] dout);
    bus.sample_valid = 1'b1; bus.num1 = n1; bus.num2 = n2; bus.out_sel = sel;
    @(negedge clk);
    bus.sample_valid = 1'b0; bus.dut_out = dout;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; on = 1'b0; clear = 1'b0;
    bus.sample_valid = 1'b0; bus.num1 = '0; bus.num2 = '0; bus.out_sel = '0; bus.dut_out = '0;
    @(negedge clk);
    on = 1'b1;
    do_op(8'h57, 8'h1A, 7'h01, 8'h70);
    #2 rst = 1'b0;
    #1;
    checks++; if (pass_a !== 16'd0) begin errors++; $display("[TB] FAIL reset_pass got=%0h exp=0", pass_a); end
    checks++; if (fail_a !== 16'd0) begin errors++; $display("[TB] FAIL reset_fail got=%0h exp=0", fail_a); end
    checks++; if (st_a !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=0", st_a); end
    checks++; if (eexp_a !== 8'h00 || egot_a !== 8'h00 || esel_a !== 7'h00) begin errors++; $display("[TB] FAIL reset_err got=%0h/%0h/%0h exp=0/0/0", eexp_a, egot_a, esel_a); end
    checks++; if (mis_a !== 1'b0 || ill_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got=%0b%0b exp=00", mis_a, ill_a); end
    @(negedge clk);
    rst = 1'b1; on = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_pass();
    on = 1'b1;
    do_op(8'h57, 8'h1A, 7'h01, 8'h71);
    checks++; if (pass_a !== 16'd1) begin errors++; $display("[TB] FAIL add_pass_cnt got=%0d exp=1", pass_a); end
    checks++; if (st_a !== 2'd1) begin errors++; $display("[TB] FAIL add_state got=%0d exp=1", st_a); end
    checks++; if (mis_a !== 1'b0) begin errors++; $display("[TB] FAIL add_mismatch got=%0b exp=0", mis_a); end
    checks++; if (fail_a !== 16'd0) begin errors++; $display("[TB] FAIL add_fail_cnt got=%0d exp=0", fail_a); end
  endtask

  task automatic test_ops();
    do_op(8'h57, 8'h1A, 7'h04, 8'h12);
    checks++; if (pass_a !== 16'd2) begin errors++; $display("[TB] FAIL and_pass got=%0d exp=2", pass_a); end
    do_op(8'h00, 8'h01, 7'h02, 8'hFF);
    checks++; if (pass_a !== 16'd3) begin errors++; $display("[TB] FAIL sub_wrap got=%0d exp=3", pass_a); end
    do_op(8'h57, 8'h1A, 7'h08, 8'h5F);
    do_op(8'h57, 8'h1A, 7'h10, 8'h4D);
    do_op(8'h57, 8'h1A, 7'h20, 8'hA8);
    do_op(8'h57, 8'h1A, 7'h40, 8'h57);
    checks++; if (pass_a !== 16'd7) begin errors++; $display("[TB] FAIL logic_ops_pass got=%0d exp=7", pass_a); end
    checks++; if (fail_a !== 16'd0) begin errors++; $display("[TB] FAIL logic_ops_fail got=%0d exp=0", fail_a); end
  endtask

  task automatic test_illegal();
    bus.sample_valid = 1'b1; bus.num1 = 8'h57; bus.num2 = 8'h1A; bus.out_sel = 7'h09;
    @(negedge clk);
    checks++; if (ill_a !== 1'b1) begin errors++; $display("[TB] FAIL illegal_pulse got=%0b exp=1", ill_a); end
    bus.sample_valid = 1'b0; bus.dut_out = 8'h00;
    @(negedge clk);
    checks++; if (ill_a !== 1'b0) begin errors++; $display("[TB] FAIL illegal_one_cycle got=%0b exp=0", ill_a); end
    checks++; if (pass_a !== 16'd7 || fail_a !== 16'd0) begin errors++; $display("[TB] FAIL illegal_counters got=%0d/%0d exp=7/0", pass_a, fail_a); end
  endtask

  task automatic test_mismatch();
    do_op(8'h57, 8'h1A, 7'h01, 8'h70);
    checks++; if (mis_a !== 1'b1) begin errors++; $display("[TB] FAIL mm_pulse got=%0b exp=1", mis_a); end
    checks++; if (fail_a !== 16'd1) begin errors++; $display("[TB] FAIL mm_fail_cnt got=%0d exp=1", fail_a); end
    checks++; if (eexp_a !== 8'h71) begin errors++; $display("[TB] FAIL mm_err_exp got=%0h exp=71", eexp_a); end
    checks++; if (egot_a !== 8'h70) begin errors++; $display("[TB] FAIL mm_err_got got=%0h exp=70", egot_a); end
    checks++; if (esel_a !== 7'h01) begin errors++; $display("[TB] FAIL mm_err_sel got=%0h exp=01", esel_a); end
    checks++; if (st_a !== 2'd2) begin errors++; $display("[TB] FAIL mm_state got=%0d exp=2", st_a); end
    do_op(8'h57, 8'h1A, 7'h01, 8'h71);
    checks++; if (pass_a !== 16'd7 || fail_a !== 16'd1) begin errors++; $display("[TB] FAIL frozen_pass got=%0d/%0d exp=7/1", pass_a, fail_a); end
    checks++; if (mis_a !== 1'b0) begin errors++; $display("[TB] FAIL frozen_pulse got=%0b exp=0", mis_a); end
    do_op(8'h57, 8'h1A, 7'h04, 8'h00);
    checks++; if (fail_a !== 16'd1 || egot_a !== 8'h70) begin errors++; $display("[TB] FAIL frozen_fail got=%0d/%0h exp=1/70", fail_a, egot_a); end
    checks++; if (st_a !== 2'd2) begin errors++; $display("[TB] FAIL frozen_state got=%0d exp=2", st_a); end
  endtask

  task automatic test_clear_collision();
    clear = 1'b1;
    bus.sample_valid = 1'b1; bus.num1 = 8'h57; bus.num2 = 8'h1A; bus.out_sel = 7'h01;
    @(negedge clk);
    clear = 1'b0; bus.sample_valid = 1'b0; bus.dut_out = 8'h71;
    @(negedge clk);
    checks++; if (pass_a !== 16'd0 || fail_a !== 16'd0) begin errors++; $display("[TB] FAIL clear_counters got=%0d/%0d exp=0/0", pass_a, fail_a); end
    checks++; if (st_a !== 2'd0) begin errors++; $display("[TB] FAIL clear_state got=%0d exp=0", st_a); end
    checks++; if (eexp_a !== 8'h00 || egot_a !== 8'h00 || esel_a !== 7'h00) begin errors++; $display("[TB] FAIL clear_err got=%0h/%0h/%0h exp=0/0/0", eexp_a, egot_a, esel_a); end
    @(negedge clk);
    checks++; if (pass_a !== 16'd0 || st_a !== 2'd0) begin errors++; $display("[TB] FAIL clear_dropped got=%0d/%0d exp=0/0", pass_a, st_a); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    on = 1'b1;
    bus.sample_valid = 1'b1; bus.num1 = 8'h57; bus.num2 = 8'h1A; bus.out_sel = 7'h01;
    @(negedge clk);
    bus.out_sel = 7'h04;
    @(negedge clk);
    bus.out_sel = 7'h08;
    @(negedge clk);
    bus.sample_valid = 1'b0; on = 1'b0; bus.dut_out = 8'h71;
    @(negedge clk);
    bus.dut_out = 8'h12;
    @(negedge clk);
    bus.dut_out = 8'h5F;
    @(negedge clk);
    checks++; if (pass_b !== 16'd3 || fail_b !== 16'd0) begin errors++; $display("[TB] FAIL lat3_counts got=%0d/%0d exp=3/0", pass_b, fail_b); end
    checks++; if (st_b !== 2'd1) begin errors++; $display("[TB] FAIL lat3_run got=%0d exp=1", st_b); end
    @(negedge clk);
    checks++; if (st_b !== 2'd0) begin errors++; $display("[TB] FAIL lat3_idle got=%0d exp=0", st_b); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    on = 1'b1;
    bus.sample_valid = 1'b1; bus.num1 = 8'h57; bus.num2 = 8'h1A; bus.out_sel = 7'h01;
    @(negedge clk);
    bus.out_sel = 7'h04;
    @(negedge clk);
    bus.sample_valid = 1'b0; bus.dut_out = 8'h70;
    checks++; if (st_b !== 2'd1) begin errors++; $display("[TB] FAIL midrst_run got=%0d exp=1", st_b); end
    #2 rst = 1'b0;
    #1;
    checks++; if (pass_b !== 16'd0 || fail_b !== 16'd0 || st_b !== 2'd0 || mis_b !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async got=%0d/%0d/%0d/%0b exp=0/0/0/0", pass_b, fail_b, st_b, mis_b); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (pass_b !== 16'd0 || fail_b !== 16'd0 || eexp_b !== 8'h00) begin errors++; $display("[TB] FAIL midrst_no_compare got=%0d/%0d/%0h exp=0/0/0", pass_b, fail_b, eexp_b); end
    checks++; if (st_b !== 2'd0) begin errors++; $display("[TB] FAIL midrst_state got=%0d exp=0", st_b); end
  endtask

  task automatic test_saturation();
    apply_reset();
    on = 1'b1;
    for (int i = 0; i < 17; i++) begin
      do_op(8'h01, 8'h02, 7'h01, 8'h03);
      if (i == 14) begin
        checks++; if (pass_c !== 4'hF) begin errors++; $display("[TB] FAIL sat_reach got=%0h exp=f", pass_c); end
      end
    end
    checks++; if (pass_c !== 4'hF) begin errors++; $display("[TB] FAIL sat_hold got=%0h exp=f", pass_c); end
    checks++; if (fail_c !== 4'h0 || st_c !== 2'd1) begin errors++; $display("[TB] FAIL sat_fail_state got=%0h/%0d exp=0/1", fail_c, st_c); end
    on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_pass();
    test_ops();
    test_illegal();
    test_mismatch();
    test_clear_collision();
    test_back_to_back();
    test_reset_midflight();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
